// File: rtl/mem_arbiter_if.sv
// Bus bundle between the pipeline fetch/load-store ports, the arbiter and the unified memory.
// The slave modport is the arbiter's view; master is the pipeline-plus-memory side.
interface mem_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             i_req;
  logic [WIDTH-1:0] i_addr;
  logic [WIDTH-1:0] i_rdata;
  logic             i_ready;
  logic             i_stall;

  logic             d_req;
  logic             d_we;
  logic [WIDTH-1:0] d_addr;
  logic [WIDTH-1:0] d_wdata;
  logic [WIDTH-1:0] d_rdata;
  logic             d_ready;
  logic             d_stall;

  logic             m_valid;
  logic             m_we;
  logic [WIDTH-1:0] m_addr;
  logic [WIDTH-1:0] m_wdata;
  logic [WIDTH-1:0] m_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output i_rdata, i_ready, i_stall, d_rdata, d_ready, d_stall,
           m_valid, m_we, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  i_rdata, i_ready, i_stall, d_rdata, d_ready, d_stall,
           m_valid, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter sharing one fixed-latency single-port memory between fetch (I) and load/store (D).
// Define MEM_ARB_RR_EN for round-robin tie breaking; otherwise D has fixed priority over I.
module mem_arbiter #(
  parameter int WIDTH = 32,
  parameter int LAT   = 2
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam int CW = $clog2(LAT + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LAT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q,   state_d;
  logic [CW-1:0]    cnt_q,     cnt_d;
  logic             grant_q,   grant_d;     // 1 = D port owns the access
  logic             m_valid_q, m_valid_d;
  logic             m_we_q,    m_we_d;
  logic [WIDTH-1:0] m_addr_q,  m_addr_d;
  logic [WIDTH-1:0] m_wdata_q, m_wdata_d;
  logic [WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic             i_ready_q, i_ready_d;
  logic             d_ready_q, d_ready_d;
  logic             pick_d;

`ifdef MEM_ARB_RR_EN
  logic             last_grant_q, last_grant_d;

  // On a tie, hand the memory to whichever port did not win last time.
  always_comb begin
    if (bus.d_req && bus.i_req) begin
      pick_d = ~last_grant_q;
    end else begin
      pick_d = bus.d_req;
    end
  end
`else
  always_comb begin
    pick_d = bus.d_req;
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    m_valid_d = m_valid_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_ready_d = i_ready_q;
    d_ready_d = d_ready_q;
`ifdef MEM_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif

    case (state_q)
      IDLE: begin
        m_valid_d = 1'b0;
        if (bus.i_req || bus.d_req) begin
          state_d   = WAIT;
          cnt_d     = CNT_LOAD;
          grant_d   = pick_d;
          m_valid_d = 1'b1;
          m_we_d    = pick_d & bus.d_we;
          m_addr_d  = pick_d ? bus.d_addr  : bus.i_addr;
          m_wdata_d = pick_d ? bus.d_wdata : '0;
`ifdef MEM_ARB_RR_EN
          last_grant_d = pick_d;
`endif
        end
      end

      WAIT: begin
        // The command strobe only covers the first WAIT cycle.
        m_valid_d = 1'b0;
        if (cnt_q == CNT_ONE) begin
          state_d = RESP;
          cnt_d   = '0;
          if (grant_q) begin
            d_ready_d = 1'b1;
            if (!m_we_q) begin
              d_rdata_d = bus.m_rdata;
            end
          end else begin
            i_ready_d = 1'b1;
            i_rdata_d = bus.m_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      RESP: begin
        state_d   = IDLE;
        i_ready_d = 1'b0;
        d_ready_d = 1'b0;
      end

      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        m_valid_d = 1'b0;
        i_ready_d = 1'b0;
        d_ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      grant_q   <= 1'b0;
      m_valid_q <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      m_valid_q <= m_valid_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ready_q <= i_ready_d;
      d_ready_q <= d_ready_d;
`ifdef MEM_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign bus.m_valid = m_valid_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.i_ready = i_ready_q;
  assign bus.d_ready = d_ready_q;

  // Stalls are combinational so the hazard unit releases IF/MEM in the ready cycle.
  assign bus.i_stall = bus.i_req & ~i_ready_q;
  assign bus.d_stall = bus.d_req & ~d_ready_q;

endmodule
